// File: rtl/serial_subtractor.sv
// Bit-serial full subtractor: minuend - subtrahend - borrow_in, LSB first,
// one bit per clock through a single full-subtractor cell and a borrow flop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shift_a, shift_a_n;
  logic [WIDTH-1:0] shift_b, shift_b_n;
  logic [WIDTH-1:0] res, res_n;
  logic [WIDTH-1:0] diff_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             brw, brw_n;
  logic             bout_n;
  logic             done_n;
  logic             a, b, d, brw_next;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      shift_a    <= '0;
      shift_b    <= '0;
      res        <= '0;
      cnt        <= '0;
      brw        <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      shift_a    <= shift_a_n;
      shift_b    <= shift_b_n;
      res        <= res_n;
      cnt        <= cnt_n;
      brw        <= brw_n;
      diff       <= diff_n;
      borrow_out <= bout_n;
      done       <= done_n;
    end
  end

  // The one full-subtractor cell, fed from the operand LSBs.
  always_comb begin
    a        = shift_a[0];
    b        = shift_b[0];
    d        = a ^ b ^ brw;
    brw_next = (~a & b) | (~(a ^ b) & brw);
  end

  always_comb begin
    state_n   = state;
    shift_a_n = shift_a;
    shift_b_n = shift_b;
    res_n     = res;
    cnt_n     = cnt;
    brw_n     = brw;
    diff_n    = diff;
    bout_n    = borrow_out;
    done_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          shift_a_n = minuend;
          shift_b_n = subtrahend;
          brw_n     = borrow_in;
          cnt_n     = '0;
          state_n   = RUN;
        end
      end
      RUN: begin
        shift_a_n = shift_a >> 1;
        shift_b_n = shift_b >> 1;
        res_n     = {d, res[WIDTH-1:1]};
        brw_n     = brw_next;
        cnt_n     = cnt + CW'(1);
        if (cnt == LAST) begin
          diff_n  = {d, res[WIDTH-1:1]};
          bout_n  = brw_next;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized bench for serial_subtractor at WIDTH=8 and WIDTH=4,
// checked against plain-arithmetic A - B - bin.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       st8, bi8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bo8;
  logic [7:0] diff8;
  logic       st4, bi4;
  logic [3:0] a4, b4;
  logic       busy4, done4, bo4;
  logic [3:0] diff4;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] last_diff;
  logic       last_bo;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .sys_clk(clk), .sys_rst(rst), .start(st8),
    .minuend(a8), .subtrahend(b8), .borrow_in(bi8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .sys_clk(clk), .sys_rst(rst), .start(st4),
    .minuend(a4), .subtrahend(b4), .borrow_in(bi4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic bin, input int glitch);
    logic [8:0] exp;
    int n;
    exp = {1'b0, a} - {1'b0, b} - 9'(bin);
    st8 = 1'b1; a8 = a; b8 = b; bi8 = bin;
    tick();
    st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
    n = 0;
    while (!done8 && n < 20) begin
      check("busy8", 32'(busy8), 32'd1);
      check("hold8", 32'({bo8, diff8}), 32'({last_bo, last_diff}));
      if (n == glitch) begin
        st8 = 1'b1; a8 = 8'h01; b8 = 8'h01; bi8 = 1'b0;
      end else begin
        st8 = 1'b0;
      end
      tick();
      n++;
    end
    st8 = 1'b0;
    check("lat8", n, 32'd8);
    check("done8", 32'(done8), 32'd1);
    check("busy_end8", 32'(busy8), 32'd0);
    check("diff8", 32'(diff8), 32'(exp[7:0]));
    check("bout8", 32'(bo8), 32'(exp[8]));
    last_diff = exp[7:0];
    last_bo   = exp[8];
    tick();
    check("pulse8", 32'(done8), 32'd0);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b,
                      input logic bin);
    logic [4:0] exp;
    int n;
    exp = {1'b0, a} - {1'b0, b} - 5'(bin);
    st4 = 1'b1; a4 = a; b4 = b; bi4 = bin;
    tick();
    st4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    n = 0;
    while (!done4 && n < 12) begin
      tick();
      n++;
    end
    check("lat4", n, 32'd4);
    check("res4", 32'({bo4, diff4}), 32'(exp));
    tick();
    check("pulse4", 32'(done4), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] qa [5];
    logic [7:0] qb [5];
    logic       qi [5];
    logic [8:0] exp;
    int         n;

    rst = 1'b1;
    st8 = 1'b0; a8 = '0; b8 = '0; bi8 = 1'b0;
    st4 = 1'b0; a4 = '0; b4 = '0; bi4 = 1'b0;
    repeat (2) tick();
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_bout", 32'(bo8), 32'd0);
    rst = 1'b0;
    last_diff = '0;
    last_bo   = 1'b0;

    run8(8'h5A, 8'h23, 1'b0, -1);
    run8(8'h10, 8'h20, 1'b0, -1);
    run8(8'h00, 8'h00, 1'b1, -1);
    run8(8'hFF, 8'hFF, 1'b0, -1);
    run8(8'hC3, 8'h3C, 1'b1, 3);

    // Abort mid-run with reset.
    st8 = 1'b1; a8 = 8'h77; b8 = 8'h11; bi8 = 1'b0;
    tick();
    st8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_diff", 32'(diff8), 32'd0);
    check("abort_bout", 32'(bo8), 32'd0);
    rst = 1'b0;
    last_diff = '0;
    last_bo   = 1'b0;
    repeat (12) begin
      tick();
      check("abort_nodone", 32'(done8), 32'd0);
    end

    // Back-to-back with start held high.
    for (int k = 0; k < 5; k++) begin
      qa[k] = 8'($urandom);
      qb[k] = 8'($urandom);
      qi[k] = 1'($urandom);
    end
    st8 = 1'b1; a8 = qa[0]; b8 = qb[0]; bi8 = qi[0];
    tick();
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!done8 && n < 20) begin
        tick();
        n++;
      end
      exp = {1'b0, qa[k]} - {1'b0, qb[k]} - 9'(qi[k]);
      check("b2b_lat", n, 32'd8);
      check("b2b_res", 32'({bo8, diff8}), 32'(exp));
      last_diff = exp[7:0];
      last_bo   = exp[8];
      if (k < 4) begin
        a8 = qa[k+1]; b8 = qb[k+1]; bi8 = qi[k+1];
      end else begin
        st8 = 1'b0;
      end
      tick();
      check("b2b_pulse", 32'(done8), 32'd0);
    end

    for (int k = 0; k < 30; k++)
      run8(8'($urandom), 8'($urandom), 1'($urandom),
           int'($urandom_range(0, 12)));

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      run4(v[3:0], v[7:4], v[8]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
